// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad: command codes, FSM states and
// the 4x4 key map.
package calc_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_0   = 4'd0;
  localparam cmd_t CMD_1   = 4'd1;
  localparam cmd_t CMD_2   = 4'd2;
  localparam cmd_t CMD_3   = 4'd3;
  localparam cmd_t CMD_4   = 4'd4;
  localparam cmd_t CMD_5   = 4'd5;
  localparam cmd_t CMD_6   = 4'd6;
  localparam cmd_t CMD_7   = 4'd7;
  localparam cmd_t CMD_8   = 4'd8;
  localparam cmd_t CMD_9   = 4'd9;
  localparam cmd_t CMD_ADD = 4'b1010;
  localparam cmd_t CMD_SUB = 4'b1011;
  localparam cmd_t CMD_MUL = 4'b1100;
  localparam cmd_t CMD_CLR = 4'b1101;
  localparam cmd_t CMD_EQ  = 4'b1110;
  localparam cmd_t CMD_NOP = 4'b1111;

  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  function automatic cmd_t key_map(input logic [1:0] row, input logic [1:0] col);
    cmd_t code;
    case ({row, col})
      4'b00_00: code = CMD_1;
      4'b00_01: code = CMD_2;
      4'b00_10: code = CMD_3;
      4'b00_11: code = CMD_ADD;
      4'b01_00: code = CMD_4;
      4'b01_01: code = CMD_5;
      4'b01_10: code = CMD_6;
      4'b01_11: code = CMD_SUB;
      4'b10_00: code = CMD_7;
      4'b10_01: code = CMD_8;
      4'b10_10: code = CMD_9;
      4'b10_11: code = CMD_MUL;
      4'b11_00: code = CMD_CLR;
      4'b11_01: code = CMD_0;
      4'b11_10: code = CMD_EQ;
      default:  code = CMD_NOP;
    endcase
    return code;
  endfunction

  // Rows are active-low: exactly one zero bit means exactly one row pulled down.
  function automatic logic single_low(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows[r]) idx = 2'(r);
    end
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/calc_keypad_if.sv
// Keypad matrix and command bundle between the scanner and its surroundings.
interface calc_keypad_if;
  import calc_pkg::*;

  logic [3:0] row_in;
  logic [3:0] col_out;
  cmd_t       cmd;
  logic       cmd_valid;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output cmd,
    output cmd_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  cmd,
    input  cmd_valid,
    input  key_held
  );

endinterface

// File: rtl/calc_debounce.sv
// Compare-and-count stability timer, shared by press and release qualification.
module calc_debounce #(
  parameter int DEBOUNCE_CYC = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic match,
  output logic hit
);

  localparam int            CW     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYC);

  logic [CW-1:0] cnt_p0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == TARGET) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_p0 <= '0;
    end else if (match) begin
      cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  // High on the matching cycle whose increment lands on the target.
  assign hit = match && (sat_inc(cnt_p0) == TARGET);

endmodule

// File: rtl/calc_keypad.sv
// 4x4 keypad scanner: rotates column drive, debounces one key at a time and
// emits a single registered command pulse per accepted press.
module calc_keypad
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 5000
) (
  input  logic           clock,
  input  logic           reset,
  calc_keypad_if.master  kp
);

  localparam int            DW       = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cap_rows_q, cap_rows_d;
  cmd_t          cap_code_q, cap_code_d;

  logic [3:0]    col_p1;
  cmd_t          cmd_p1, cmd_d;
  logic          vld_p1, vld_d;
  logic          held_p1, held_d;

  logic          dbc_clr;
  logic          dbc_match;
  logic          dbc_hit;

  calc_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .clr   (dbc_clr),
    .match (dbc_match),
    .hit   (dbc_hit)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    col_d      = col_q;
    cap_rows_d = cap_rows_q;
    cap_code_d = cap_code_q;
    cmd_d      = cmd_p1;
    vld_d      = 1'b0;
    held_d     = held_p1;
    dbc_clr    = 1'b0;
    dbc_match  = 1'b0;

    case (state_q)
      ST_SCAN: begin
        cmd_d  = CMD_NOP;
        held_d = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (single_low(kp.row_in)) begin
            state_d    = ST_DEBOUNCE;
            cap_rows_d = kp.row_in;
            cap_code_d = key_map(low_index(kp.row_in), col_q);
            dbc_clr    = 1'b1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      ST_DEBOUNCE: begin
        cmd_d     = CMD_NOP;
        dbc_match = (kp.row_in == cap_rows_q);
        if (!dbc_match) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end else if (dbc_hit) begin
          // The reserved key still latches into PRESSED so it blocks others.
          state_d = ST_PRESSED;
          held_d  = 1'b1;
          cmd_d   = cap_code_q;
          vld_d   = (cap_code_q != CMD_NOP);
        end
      end

      ST_PRESSED: begin
        held_d = 1'b1;
        cmd_d  = cap_code_q;
        if (kp.row_in == ROWS_IDLE) begin
          state_d = ST_RELEASE;
          dbc_clr = 1'b1;
        end
      end

      ST_RELEASE: begin
        dbc_match = (kp.row_in == ROWS_IDLE);
        if (!dbc_match) begin
          state_d = ST_PRESSED;
        end else if (dbc_hit) begin
          state_d = ST_SCAN;
          cmd_d   = CMD_NOP;
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // ---- registered control and outputs ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SCAN;
      div_q   <= '0;
      col_q   <= 2'd0;
      col_p1  <= col_drive(2'd0);
      cmd_p1  <= CMD_NOP;
      vld_p1  <= 1'b0;
      held_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      col_p1  <= col_drive(col_d);
      cmd_p1  <= cmd_d;
      vld_p1  <= vld_d;
      held_p1 <= held_d;
    end
  end

  always_ff @(posedge clock) begin
    cap_rows_q <= cap_rows_d;
    cap_code_q <= cap_code_d;
  end

  assign kp.col_out   = col_p1;
  assign kp.cmd       = cmd_p1;
  assign kp.cmd_valid = vld_p1;
  assign kp.key_held  = held_p1;

endmodule

// File: tb/tb_calc_keypad.sv
// Scoreboard bench for calc_keypad: a key-matrix model drives rows from the
// scanned column, expected commands are queued at press time and popped on cmd_valid.
module tb_calc_keypad;

  localparam int SD = 4;
  localparam int DB = 8;

  localparam logic [3:0] KEY_CODE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hD, 4'h0, 4'hE, 4'hF
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  calc_keypad_if kp();

  calc_keypad #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp.master)
  );

  // Key matrix: a pressed switch pulls its row low while its column is driven low.
  logic       keys [4][4];
  logic [3:0] rows;
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r][c] && !kp.col_out[c]) rows[r] = 1'b0;
      end
    end
  end
  assign kp.row_in = rows;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_vld = 0;
  int         last_vld_cyc = -1;
  logic [3:0] exp_q [$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        keys[r][c] = 1'b0;
  endtask

  task automatic press(input int k, input logic expect_cmd);
    keys[k / 4][k % 4] = 1'b1;
    if (expect_cmd) exp_q.push_back(KEY_CODE[k]);
  endtask

  // Monitor: pops the scoreboard on every pulse and checks output invariants.
  always @(negedge clock) begin
    if (kp.cmd_valid === 1'b1) begin
      n_vld++;
      last_vld_cyc = cyc;
      check("cmd_valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("cmd_value", kp.cmd, exp_q.pop_front());
    end
    if (kp.key_held === 1'b0) check("cmd_nop_when_idle", kp.cmd, 4'hF);
    check("col_onehot0", $countones(~kp.col_out), 1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tr, n0, heldcnt, k, k2, hold, rel;
    logic [3:0] seen;
    logic second;

    clear_keys();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    tick(1);
    check("rst_col_out", kp.col_out, 4'b1110);
    check("rst_cmd", kp.cmd, 4'hF);
    check("rst_cmd_valid", kp.cmd_valid, 1'b0);
    check("rst_key_held", kp.key_held, 1'b0);

    // '6' at (1,2) pressed from the first scan cycle and held 100 cycles.
    press(6, 1'b1);
    reset = 1'b0;
    t0 = cyc;
    n0 = n_vld;
    for (int i = 0; i < 60 && n_vld == n0; i++) tick(1);
    check("six_pulse_seen", n_vld - n0, 1);
    check("six_latency", last_vld_cyc - t0, SD * 3 + DB);
    tick(100 - (cyc - t0));
    check("six_single_pulse", n_vld - n0, 1);
    check("six_cmd_held", kp.cmd, 4'd6);
    check("six_key_held", kp.key_held, 1'b1);
    keys[1][2] = 1'b0;
    tr = cyc;
    tick(DB);
    check("six_held_before_release_done", kp.key_held, 1'b1);
    tick(1);
    check("six_release_cycles", cyc - tr, DB + 1);
    check("six_held_after_release", kp.key_held, 1'b0);
    check("six_cmd_after_release", kp.cmd, 4'hF);
    tick(10);

    // Reset landing on the edge where the press would have been accepted.
    reset = 1'b1;
    tick(3);
    keys[1][2] = 1'b1;
    reset = 1'b0;
    t0 = cyc;
    n0 = n_vld;
    tick(SD * 3 + DB - 1);
    reset = 1'b1;
    tick(1);
    check("rstacc_cmd_valid", kp.cmd_valid, 1'b0);
    check("rstacc_key_held", kp.key_held, 1'b0);
    check("rstacc_col_out", kp.col_out, 4'b1110);
    keys[1][2] = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(5);
    check("rstacc_no_pulse", n_vld - n0, 0);

    // Contact bounce on (0,0).
    n0 = n_vld;
    for (int i = 0; i < 14; i++) begin
      keys[0][0] = (i % 2 == 0);
      tick(3);
    end
    keys[0][0] = 1'b0;
    tick(20);
    check("bounce_no_pulse", n_vld - n0, 0);

    // Two rows low on column 1: never captured, scan keeps rotating.
    n0 = n_vld;
    seen = 4'h0;
    heldcnt = 0;
    keys[0][1] = 1'b1;
    keys[2][1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      for (int c = 0; c < 4; c++) begin
        if (kp.col_out == ~(4'b0001 << c)) seen[c] = 1'b1;
      end
      if (kp.key_held) heldcnt++;
    end
    clear_keys();
    tick(10);
    check("dual_row_all_cols", seen, 4'hF);
    check("dual_row_no_hold", heldcnt, 0);
    check("dual_row_no_pulse", n_vld - n0, 0);

    // Sequence 1, 2, ADD, 3, EQ.
    n0 = n_vld;
    foreach (KEY_CODE[i]) begin end
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: k = 0;
        1: k = 1;
        2: k = 3;
        3: k = 2;
        default: k = 14;
      endcase
      press(k, 1'b1);
      tick(30);
      clear_keys();
      tick(30);
    end
    check("sequence_pulses", n_vld - n0, 5);

    // Reserved key (3,3): held but silent.
    n0 = n_vld;
    press(15, 1'b0);
    tick(40);
    check("reserved_key_held", kp.key_held, 1'b1);
    check("reserved_cmd", kp.cmd, 4'hF);
    clear_keys();
    tick(20);
    check("reserved_released", kp.key_held, 1'b0);
    check("reserved_no_pulse", n_vld - n0, 0);

    // Reset while PRESSED.
    press(8, 1'b1);
    for (int i = 0; i < 60 && kp.key_held !== 1'b1; i++) tick(1);
    check("rstp_held_before", kp.key_held, 1'b1);
    reset = 1'b1;
    clear_keys();
    tick(1);
    check("rstp_col_out", kp.col_out, 4'b1110);
    check("rstp_cmd", kp.cmd, 4'hF);
    check("rstp_key_held", kp.key_held, 1'b0);
    check("rstp_cmd_valid", kp.cmd_valid, 1'b0);
    reset = 1'b0;
    tick(20);

    // Random presses, sometimes with a second key pressed while the first is held.
    n0 = n_vld;
    for (int it = 0; it < 24; it++) begin
      k      = $urandom_range(0, 15);
      k2     = (k + $urandom_range(1, 15)) % 16;
      hold   = $urandom_range(34, 50);
      rel    = $urandom_range(12, 30);
      second = ($urandom_range(0, 2) == 0);
      press(k, KEY_CODE[k] != 4'hF);
      tick(28);
      if (second) press(k2, 1'b0);
      tick(hold - 28);
      clear_keys();
      tick(rel);
    end

    tick(30);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_keypad.md
CALC_KEYPAD -- requirements
Module: calc_keypad

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column stays driven during scanning (minimum 2).
REQ-002 Parameter DEBOUNCE_CYC, default 5000: consecutive stable cycles required to accept a press or a release (minimum 1).
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 row_in  input  4  keypad rows, active-low (pulled up); bit r = row r.
REQ-006 col_out  output  4  keypad column drive, active-low, one-hot-zero; bit c = column c.
REQ-007 cmd  output  4  calculator command code, carried to the calculator's cmd input.
REQ-008 cmd_valid  output  1  one-cycle pulse marking acceptance of a new command.
REQ-009 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 Key map (row,col)->code:
- row0: 1,2,3,ADD=4'b1010
- row1: 4,5,6,SUB=4'b1011
- row2: 7,8,9,MUL=4'b1100
- row3: CLR=4'b1101, 0, EQ=4'b1110, reserved
REQ-011 CMD_NOP=4'b1111; the reserved key (3,3) maps to CMD_NOP and SHALL never produce cmd_valid.
REQ-012 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 SCAN behaviour:
- col_out rotates 1110->1101->1011->0111->1110, advancing every SCAN_DIV cycles.
- row_in is sampled only on the last cycle of each column period.
REQ-014 SCAN, sample with exactly one row low:
- capture (row,col), move to DEBOUNCE, freeze col_out, clear the debounce counter.
REQ-015 SCAN, sample with zero or with two or more rows low: keep scanning; no capture.
REQ-016 DEBOUNCE behaviour:
- the counter increments each cycle that row_in equals the captured pattern.
- any mismatch returns to SCAN with the next column, with no output.
REQ-017 DEBOUNCE completion, on the cycle the counter reaches DEBOUNCE_CYC:
- mapped code not CMD_NOP: cmd_valid=1 for exactly that cycle, cmd=mapped code; move to PRESSED.
- mapped code is CMD_NOP: move to PRESSED without a pulse.
REQ-018 PRESSED: key_held=1 and cmd holds the code; row_in all-high moves to RELEASE with the counter cleared.
REQ-019 RELEASE behaviour:
- the counter increments while row_in==4'b1111; any low row returns to PRESSED.
- at DEBOUNCE_CYC: move to SCAN, cmd=CMD_NOP, key_held=0, scanning resumes at the column after the captured one.
REQ-020 cmd SHALL equal CMD_NOP in SCAN and DEBOUNCE.
REQ-021 Holding a key indefinitely SHALL yield exactly one cmd_valid pulse.
REQ-022 Pressing a second key while one is held SHALL be ignored until release is accepted.
REQ-023 Counters SHALL saturate, never wrap; widths are $clog2(param+1).

Reset
REQ-024 While reset=1, on each clock edge:
- state=SCAN, col_out=4'b1110, cmd=CMD_NOP, cmd_valid=0, key_held=0, all counters 0.
REQ-025 Reset asserted mid-operation (any state) SHALL override all other behaviour on that edge; no cmd_valid is emitted that cycle.

Structure
REQ-026 Package calc_pkg SHALL hold:
- the cmd_t 4-bit code constants (digits, ADD, SUB, MUL, CLR, EQ, CMD_NOP);
- the FSM state enum;
- the 4x4 key-map function.
REQ-027 calc_top SHALL import calc_pkg for the same code constants.
REQ-028 One sub-module, calc_debounce, SHALL hold the compare/saturating counter, reused for press and release.
REQ-029 Outputs SHALL be registered; no combinational path from row_in to any output.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8)
REQ-030 Reset check: hold reset 3 cycles -> col_out=1110, cmd=1111, cmd_valid=0, key_held=0.
REQ-031 Press '6' at (1,2) and hold 100 cycles:
- exactly one cmd_valid, with cmd=4'd6, 8 cycles after the column-2 sample;
- key_held=1 until 8 cycles after release, then cmd=1111.
REQ-032 Bounce on (0,0): toggle row0 low/high every 3 cycles for 40 cycles -> no cmd_valid.
REQ-033 Rows 0 and 2 both low on column 1 -> no capture; scanning continues (col_out keeps rotating).
REQ-034 Sequence 1,2,ADD,3,EQ (each held 30 cycles, released 30 cycles) -> cmd_valid pulses with cmd=1,2,1010,3,1110 in order.
REQ-035 Further directed cases:
- reset asserted in PRESSED -> next cycle SCAN, cmd=1111, key_held=0;
- key (3,3) pressed -> key_held=1, no cmd_valid.
